// File: rtl/scratchpad_feature_loader.sv
// Write sequencer that streams bus beats into the scratchpad feature memory,
// walking lines inside each group, then signalling completion to the controller.
module scratchpad_feature_loader #(
    parameter int Tn             = 8,
    parameter int KERNEL_SIZE    = 5,
    parameter int FEATURE_WIDTH  = 16,
    parameter int DATA_BUS_WIDTH = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [8:0]                cfg_groups,
    input  logic [3:0]                cfg_lines,
    input  logic                      s_valid,
    input  logic [DATA_BUS_WIDTH-1:0] s_data,
    output logic                      s_ready,
    output logic                      wr_en,
    output logic [8:0]                wr_mem_group,
    output logic [3:0]                wr_mem_line,
    output logic [DATA_BUS_WIDTH-1:0] wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);
    localparam int         ELEMS = DATA_BUS_WIDTH / FEATURE_WIDTH;
    localparam logic [8:0] MAX_G = 9'(Tn);
    localparam logic [3:0] MAX_L = 4'(KERNEL_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [8:0] grp_cnt, cfg_g;
    logic [3:0] line_cnt, cfg_l;
    logic       cfg_legal, launch, beat, line_wrap, last_beat, kill;

    assign cfg_legal = (cfg_groups != '0) && (cfg_groups <= MAX_G) &&
                       (cfg_lines  != '0) && (cfg_lines  <= MAX_L);
    // abort beats start while idle, so neither a fill nor a cfg_err results
    assign launch    = (state == S_IDLE) && start && !abort;
    assign kill      = abort && ((state == S_LOAD) || (state == S_DRAIN));
    assign s_ready   = (state == S_LOAD) && !abort;
    assign beat      = s_valid && s_ready;
    assign line_wrap = (line_cnt == cfg_l - 4'd1);
    assign last_beat = line_wrap && (grp_cnt == cfg_g - 9'd1);
    assign busy      = (state == S_LOAD) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (launch && cfg_legal) state_nxt = S_LOAD;
            S_LOAD: begin
                if (abort)                  state_nxt = S_IDLE;
                else if (beat && last_beat) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = abort ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_g        <= '0;
            cfg_l        <= '0;
            grp_cnt      <= '0;
            line_cnt     <= '0;
            wr_en        <= 1'b0;
            wr_mem_group <= '0;
            wr_mem_line  <= '0;
            cfg_err      <= 1'b0;
        end else begin
            wr_en   <= beat;
            cfg_err <= launch && !cfg_legal;
            if (launch && cfg_legal) begin
                cfg_g    <= cfg_groups;
                cfg_l    <= cfg_lines;
                grp_cnt  <= '0;
                line_cnt <= '0;
            end else if (kill) begin
                grp_cnt  <= '0;
                line_cnt <= '0;
            end else if (beat) begin
                // line is the inner index; group advances on the wrapping beat
                if (line_wrap) begin
                    line_cnt <= '0;
                    grp_cnt  <= grp_cnt + 9'd1;
                end else begin
                    line_cnt <= line_cnt + 4'd1;
                end
            end
            if (beat) begin
                wr_mem_group <= grp_cnt;
                wr_mem_line  <= line_cnt;
            end
        end
    end

    // Data register filled per feature element; holds its value between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_data <= '0;
        end else if (beat) begin
            for (int e = 0; e < ELEMS; e++)
                wr_data[e*FEATURE_WIDTH +: FEATURE_WIDTH] <= s_data[e*FEATURE_WIDTH +: FEATURE_WIDTH];
        end
    end

endmodule

// File: tb/tb_scratchpad_feature_loader.sv
// Scoreboard bench: a fill-level model predicts every write, done and cfg_err;
// a separate monitor pops predictions whenever the loader writes.
module tb_scratchpad_feature_loader;
    localparam int TN  = 8;
    localparam int KS  = 5;
    localparam int DBW = 128;

    logic           clk = 0, rst = 0, start = 0, abort = 0, s_valid = 0;
    logic [8:0]     cfg_groups = '0;
    logic [3:0]     cfg_lines = '0;
    logic [DBW-1:0] s_data = '0;
    logic           s_ready, wr_en, busy, done, cfg_err;
    logic [8:0]     wr_mem_group;
    logic [3:0]     wr_mem_line;
    logic [DBW-1:0] wr_data;

    scratchpad_feature_loader #(.Tn(TN), .KERNEL_SIZE(KS), .FEATURE_WIDTH(16), .DATA_BUS_WIDTH(DBW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_groups(cfg_groups), .cfg_lines(cfg_lines),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wr_en(wr_en), .wr_mem_group(wr_mem_group), .wr_mem_line(wr_mem_line),
        .wr_data(wr_data), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct { int grp; int line; logic [DBW-1:0] data; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    int total = 0, bad = 0, cyc = 0;
    int wr_cnt = 0, done_cnt = 0, rdy_cnt = 0, err_cnt = 0;

    // model state: one fill in flight, beats counted, completion cycles predicted
    bit m_active = 0, m_ready, m_busy;
    int m_g = 0, m_l = 0, m_k = 0;
    int done_due = -1, err_due = -1, drain_cyc = -1, idle_from = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [DBW-1:0] act, logic [DBW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decides acceptance, predicts addresses, done and cfg_err.
    always @(negedge clk) begin
        if (rst) begin
            m_active = 0; exp_q.delete();
            done_due = -1; err_due = -1; drain_cyc = -1; idle_from = 0;
        end else begin
            m_ready = m_active && !abort;
            m_busy  = m_active || (cyc == drain_cyc);
            if (s_ready || m_ready) check("s_ready", s_ready, m_ready);
            if (busy || m_busy) check("busy", busy, m_busy);
            if (abort && m_active) begin
                m_active = 0; idle_from = cyc + 1;
            end else if (abort && cyc == drain_cyc) begin
                done_due = -1; idle_from = cyc + 1;
            end
            if (m_ready && s_valid) begin
                exp_q.push_back('{m_k / m_l, m_k % m_l, s_data});
                m_k++;
                if (m_k == m_g * m_l) begin
                    m_active = 0; drain_cyc = cyc + 1; done_due = cyc + 2; idle_from = cyc + 3;
                end
            end
            if (start && !abort && !m_active && cyc >= idle_from) begin
                if (cfg_groups >= 1 && cfg_groups <= TN && cfg_lines >= 1 && cfg_lines <= KS) begin
                    m_active = 1; m_g = int'(cfg_groups); m_l = int'(cfg_lines); m_k = 0;
                end else begin
                    err_due = cyc + 1;
                end
            end
        end
    end

    // Monitor: consumes predictions whenever the loader presents a write.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got (%0d,%0d) expected none", wr_mem_group, wr_mem_line);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_group", wr_mem_group, mon_e.grp);
                    check("wr_line", wr_mem_line, mon_e.line);
                    check("wr_data", wr_data, mon_e.data);
                end
            end
            if (done || done_due == cyc) check("done", done, done_due == cyc);
            if (cfg_err || err_due == cyc) check("cfg_err", cfg_err, err_due == cyc);
            wr_cnt += int'(wr_en); done_cnt += int'(done);
            rdy_cnt += int'(s_ready); err_cnt += int'(cfg_err);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(int g, int l);
        cfg_groups = 9'(g); cfg_lines = 4'(l); start = 1;
        tick();
        start = 0;
    endtask

    // mode 0: valid held, data = beat index; 1: valid toggles; 2: random valid
    task automatic stream(int mode, int abort_after, int restart_after, int budget);
        bit fin = 0;
        for (int i = 0; i < budget && !fin; i++) begin
            if (!m_active && cyc >= idle_from) begin
                fin = 1;
            end else begin
                s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : ($urandom_range(0, 3) != 0);
                s_data  = (mode == 0) ? DBW'(m_k) : {$urandom, $urandom, $urandom, $urandom};
                abort   = (abort_after >= 0) && m_active && (m_k == abort_after);
                if (restart_after >= 0 && m_active && m_k == restart_after) begin
                    start = 1; cfg_groups = 9'd1; cfg_lines = 4'd1;
                end
                tick();
                abort = 0; start = 0;
            end
        end
        s_valid = 0;
        if (!fin) begin
            total++; bad++;
            $display("FAIL fill_timeout: got busy after %0d cycles expected idle", budget);
        end
    endtask

    task automatic settle();
        tick(); tick();
        check("queue_drained", exp_q.size(), 0);
    endtask

    int w0, d0, r0, e0, g, l;

    initial begin
        rst = 1;
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_group", wr_mem_group, 0);
        check("rst_line", wr_mem_line, 0);
        check("rst_data", wr_data, 0);
        rst = 0;
        tick();

        // basic 2x3 fill with held valid
        w0 = wr_cnt; d0 = done_cnt; r0 = rdy_cnt;
        pulse_start(2, 3);
        stream(0, -1, -1, 100);
        settle();
        check("t1_writes", wr_cnt - w0, 6);
        check("t1_ready_cycles", rdy_cnt - r0, 6);
        check("t1_done_count", done_cnt - d0, 1);

        // full 8x5 with toggling valid
        w0 = wr_cnt; d0 = done_cnt;
        pulse_start(TN, KS);
        stream(1, -1, -1, 400);
        settle();
        check("t2_writes", wr_cnt - w0, 40);
        check("t2_done_count", done_cnt - d0, 1);
        check("t2_last_group", wr_mem_group, TN - 1);
        check("t2_last_line", wr_mem_line, KS - 1);

        // illegal configurations
        w0 = wr_cnt; r0 = rdy_cnt; e0 = err_cnt;
        pulse_start(0, 3); tick();
        pulse_start(3, 6); tick();
        pulse_start(TN + 1, 1); tick();
        pulse_start(2, 0); tick();
        check("t3_err_count", err_cnt - e0, 4);
        check("t3_writes", wr_cnt - w0, 0);
        check("t3_ready", rdy_cnt - r0, 0);

        // abort with start while idle: nothing starts
        abort = 1; pulse_start(2, 2); abort = 0;
        tick(); tick();
        check("abort_start_busy", busy, 0);

        // abort after 3 of 10 beats, then a clean refill
        w0 = wr_cnt; d0 = done_cnt;
        pulse_start(2, 5);
        stream(0, 3, -1, 100);
        settle();
        check("t4_writes", wr_cnt - w0, 3);
        check("t4_done_count", done_cnt - d0, 0);
        w0 = wr_cnt; d0 = done_cnt;
        pulse_start(2, 5);
        stream(2, -1, -1, 200);
        settle();
        check("t4_refill_writes", wr_cnt - w0, 10);
        check("t4_refill_done", done_cnt - d0, 1);

        // restart attempt during LOAD is ignored
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        pulse_start(3, 2);
        stream(2, -1, 2, 200);
        settle();
        check("t5_writes", wr_cnt - w0, 6);
        check("t5_done_count", done_cnt - d0, 1);
        check("t5_no_err", err_cnt - e0, 0);

        // async reset mid-fill
        d0 = done_cnt;
        pulse_start(2, 3);
        s_valid = 1;
        s_data = {$urandom, $urandom, $urandom, $urandom}; tick();
        s_data = {$urandom, $urandom, $urandom, $urandom}; tick();
        s_valid = 0;
        #2 rst = 1;
        #1;
        check("t6_wr_en", wr_en, 0);
        check("t6_busy", busy, 0);
        check("t6_s_ready", s_ready, 0);
        check("t6_outputs", {wr_mem_group, wr_mem_line, wr_data, done, cfg_err}, 0);
        #3 rst = 0;
        tick();
        w0 = wr_cnt;
        pulse_start(2, 3);
        stream(2, -1, -1, 200);
        settle();
        check("t6_refill_writes", wr_cnt - w0, 6);
        check("t6_done_count", done_cnt - d0, 1);

        // single beat fill and random configurations
        w0 = wr_cnt;
        pulse_start(1, 1);
        stream(0, -1, -1, 50);
        settle();
        check("t7_single_write", wr_cnt - w0, 1);
        for (int n = 0; n < 5; n++) begin
            g = $urandom_range(1, TN); l = $urandom_range(1, KS);
            w0 = wr_cnt;
            pulse_start(g, l);
            stream(2, -1, -1, 400);
            settle();
            check("rand_writes", wr_cnt - w0, g * l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
